// File: rtl/add_pool_arb.sv
// Round-robin arbiter sharing NADD W-bit adders among NREQ requesters, with registered sums.
// Optional macro ADD_POOL_ARB_PIPE_EN adds a second result stage (2-cycle response latency).
module add_pool_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned NADD = 2,
    parameter int unsigned W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] opa,
    input  logic [NREQ*W-1:0] opb,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [NREQ*W-1:0] rsp_data,
    output logic              busy
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned AW = (NADD > 1) ? $clog2(NADD) : 1;

    logic [PW-1:0]     ptr;
    logic [PW-1:0]     ptr_next;
    logic              any_gnt;
    logic [AW:0]       n_gnt;
    logic [NREQ-1:0]   gnt_raw;
    logic [AW-1:0]     add_sel [NREQ];
    logic [PW-1:0]     add_lane [NADD];
    logic [W-1:0]      add_sum [NADD];
    logic [W-1:0]      lane_sum [NREQ];
    logic [NREQ-1:0]   rv_q;
    logic [NREQ*W-1:0] rd_q;

    // Scan from ptr with wrap; the k-th grant in scan order is bound to adder k.
    always_comb begin
        logic [PW:0]   idx;
        logic [PW-1:0] lane;
        gnt_raw  = '0;
        ptr_next = ptr;
        any_gnt  = 1'b0;
        n_gnt    = '0;
        for (int a = 0; a < NADD; a++) add_lane[a] = '0;
        for (int i = 0; i < NREQ; i++) add_sel[i] = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr} + (PW+1)'(k);
            if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
            lane = idx[PW-1:0];
            if (req[lane] && (n_gnt < (AW+1)'(NADD))) begin
                gnt_raw[lane]           = 1'b1;
                add_sel[lane]           = n_gnt[AW-1:0];
                add_lane[n_gnt[AW-1:0]] = lane;
                ptr_next = (lane == PW'(NREQ - 1)) ? '0 : lane + PW'(1);
                any_gnt  = 1'b1;
                n_gnt    = n_gnt + (AW+1)'(1);
            end
        end
    end

    always_comb begin
        for (int a = 0; a < NADD; a++) begin
            add_sum[a] = opa[32'(add_lane[a])*W +: W] + opb[32'(add_lane[a])*W +: W];
        end
        for (int i = 0; i < NREQ; i++) begin
            lane_sum[i] = add_sum[add_sel[i]];
        end
    end

    assign gnt  = rst ? '0 : gnt_raw;
    assign busy = !rst && (n_gnt == (AW+1)'(NADD));

`ifdef ADD_POOL_ARB_PIPE_EN
    logic [NREQ-1:0] pv_q;
    logic [W-1:0]    pd_q [NREQ];

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr  <= '0;
            pv_q <= '0;
            rv_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < NREQ; i++) pd_q[i] <= '0;
        end else begin
            if (any_gnt) ptr <= ptr_next;
            pv_q <= gnt_raw;
            rv_q <= pv_q;
            for (int i = 0; i < NREQ; i++) begin
                if (gnt_raw[i]) pd_q[i] <= lane_sum[i];
                if (pv_q[i]) rd_q[i*W +: W] <= pd_q[i];
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr  <= '0;
            rv_q <= '0;
            rd_q <= '0;
        end else begin
            if (any_gnt) ptr <= ptr_next;
            rv_q <= gnt_raw;
            for (int i = 0; i < NREQ; i++) begin
                if (gnt_raw[i]) rd_q[i*W +: W] <= lane_sum[i];
            end
        end
    end
`endif

    // Responses still in the register while rst is asserted must not be seen as pulses.
    assign rsp_valid = rv_q & {NREQ{~rst}};
    assign rsp_data  = rd_q;

endmodule

// File: tb/tb_add_pool_arb.sv
// Self-checking bench for add_pool_arb: directed table, corner sequences and random traffic
// compared against a transaction-level reference model.
module tb_add_pool_arb;

    localparam int NREQ = 4;
    localparam int NADD = 2;
    localparam int W    = 32;
`ifdef ADD_POOL_ARB_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] opa, opb;
    logic [NREQ-1:0]   gnt, rsp_valid;
    logic [NREQ*W-1:0] rsp_data;
    logic              busy;

    always #5 clk = ~clk;

    add_pool_arb #(.NREQ(NREQ), .NADD(NADD), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .opa       (opa),
        .opb       (opb),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: pointer, optional in-flight stage, visible response registers.
    int              mptr;
    logic [NREQ-1:0] st_v;
    logic [W-1:0]    st_d [NREQ];
    logic [NREQ-1:0] out_v;
    logic [W-1:0]    out_d [NREQ];
    int              resp_cnt [NREQ];

    task automatic check(input string name, input logic [NREQ*W-1:0] act,
                         input logic [NREQ*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NREQ*W-1:0] lanes(input logic [W-1:0] l3, input logic [W-1:0] l2,
                                                input logic [W-1:0] l1, input logic [W-1:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [NREQ*W-1:0] pack_out();
        logic [NREQ*W-1:0] v;
        for (int i = 0; i < NREQ; i++) v[i*W +: W] = out_d[i];
        return v;
    endfunction

    // Requesting lanes listed in scan order from p; the first NADD of them win.
    function automatic logic [NREQ-1:0] ref_grant(input logic [NREQ-1:0] rq, input int p,
                                                  output int np);
        int              order[$];
        logic [NREQ-1:0] g;
        g  = '0;
        np = p;
        for (int k = 0; k < NREQ; k++) begin
            int l;
            l = (p + k) % NREQ;
            if (rq[l[1:0]]) order.push_back(l);
        end
        for (int j = 0; j < order.size() && j < NADD; j++) begin
            int o;
            o        = order[j];
            g[o[1:0]] = 1'b1;
            np       = (o + 1) % NREQ;
        end
        return g;
    endfunction

    task automatic model_reset();
        mptr  = 0;
        st_v  = '0;
        out_v = '0;
        for (int i = 0; i < NREQ; i++) begin
            st_d[i]  = '0;
            out_d[i] = '0;
        end
    endtask

    // One clock cycle: drive, compare mid-cycle against the model, then advance the model.
    task automatic step(input logic r, input logic [NREQ-1:0] rq, input logic [NREQ*W-1:0] a,
                        input logic [NREQ*W-1:0] b, output logic [NREQ-1:0] mg,
                        output logic [NREQ-1:0] obs_g, output logic obs_b,
                        output logic [NREQ-1:0] obs_rv);
        int              np;
        logic [NREQ-1:0] g, av;
        logic [W-1:0]    sum [NREQ];
        logic [W-1:0]    ad [NREQ];
        rst = r;
        req = rq;
        opa = a;
        opb = b;
        #4;
        g  = ref_grant(rq, mptr, np);
        mg = r ? '0 : g;
        check("gnt", gnt, mg);
        check("busy", busy, (!r && $countones(g) == NADD));
        check("rsp_valid", rsp_valid, r ? '0 : out_v);
        check("rsp_data", rsp_data, pack_out());
        obs_g  = gnt;
        obs_b  = busy;
        obs_rv = rsp_valid;
        for (int i = 0; i < NREQ; i++) resp_cnt[i] += int'(rsp_valid[i]);
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (mg != '0) mptr = np;
            for (int i = 0; i < NREQ; i++) sum[i] = a[i*W +: W] + b[i*W +: W];
            if (LAT == 1) begin
                av = mg;
                for (int i = 0; i < NREQ; i++) ad[i] = sum[i];
            end else begin
                av = st_v;
                for (int i = 0; i < NREQ; i++) ad[i] = st_d[i];
                st_v = mg;
                for (int i = 0; i < NREQ; i++) st_d[i] = sum[i];
            end
            out_v = av;
            for (int i = 0; i < NREQ; i++) if (av[i]) out_d[i] = ad[i];
        end
        #1;
    endtask

    typedef struct {
        logic              r;
        logic [NREQ-1:0]   rq;
        logic [NREQ*W-1:0] a;
        logic [NREQ*W-1:0] b;
        logic [NREQ-1:0]   eg;
        logic              eb;
    } vec_t;

    function automatic logic [W-1:0] rand_op();
        if ($urandom_range(3) == 0) return 32'hFFFF_FFF0 + W'($urandom_range(15));
        return $urandom;
    endfunction

    initial begin
        vec_t              tbl [12];
        logic [NREQ-1:0]   mg, og, orv, pend;
        logic              ob, r;
        logic [NREQ*W-1:0] pa, pb, fa, fb, zero;

        zero = '0;
        fa   = lanes(32'd400, 32'd300, 32'd200, 32'd100);
        fb   = lanes(32'd4, 32'd3, 32'd2, 32'd1);
        tbl[0]  = '{1'b1, 4'b1111, fa, fb, 4'b0000, 1'b0};
        tbl[1]  = '{1'b1, 4'b1111, fa, fb, 4'b0000, 1'b0};
        tbl[2]  = '{1'b0, 4'b1111, fa, fb, 4'b0011, 1'b1};
        tbl[3]  = '{1'b0, 4'b1111, fa, fb, 4'b1100, 1'b1};
        tbl[4]  = '{1'b0, 4'b1111, fb, fa, 4'b0011, 1'b1};
        tbl[5]  = '{1'b0, 4'b1111, fb, fa, 4'b1100, 1'b1};
        tbl[6]  = '{1'b0, 4'b0000, zero, zero, 4'b0000, 1'b0};
        tbl[7]  = '{1'b0, 4'b0000, zero, zero, 4'b0000, 1'b0};
        tbl[8]  = '{1'b0, 4'b0111, fa, fb, 4'b0011, 1'b1};
        tbl[9]  = '{1'b0, 4'b0011, fb, fa, 4'b0011, 1'b1};  // lane 2 dropped before grant
        tbl[10] = '{1'b0, 4'b1110, fa, fa, 4'b1100, 1'b1};
        tbl[11] = '{1'b0, 4'b0001, fb, fb, 4'b0001, 1'b0};

        rst = 1'b1;
        req = '0;
        opa = '0;
        opb = '0;
        model_reset();
        for (int i = 0; i < NREQ; i++) resp_cnt[i] = 0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].r, tbl[i].rq, tbl[i].a, tbl[i].b, mg, og, ob, orv);
            check($sformatf("tbl%0d_gnt", i), og, tbl[i].eg);
            check($sformatf("tbl%0d_busy", i), ob, tbl[i].eb);
            if (i == 7) begin
                for (int l = 0; l < NREQ; l++) check($sformatf("fair_cnt%0d", l), resp_cnt[l], 2);
            end
        end

        // Single request on lane 2.
        step(1'b0, 4'b0100, lanes(0, 5, 0, 0), lanes(0, 7, 0, 0), mg, og, ob, orv);
        check("single_gnt", og, 4'b0100);
        repeat (LAT - 1) step(1'b0, '0, zero, zero, mg, og, ob, orv);
        check("single_rv", rsp_valid, 4'b0100);
        check("single_data", rsp_data[2*W +: W], 32'd12);

        // Carry-out discarded on lane 1; lane 2 result untouched.
        step(1'b0, 4'b0010, lanes(0, 0, 32'hFFFF_FFFF, 0), lanes(0, 0, 32'h2, 0), mg, og, ob, orv);
        repeat (LAT - 1) step(1'b0, '0, zero, zero, mg, og, ob, orv);
        check("wrap_rv", rsp_valid, 4'b0010);
        check("wrap_data", rsp_data[1*W +: W], 32'h0000_0001);
        check("wrap_other", rsp_data[2*W +: W], 32'd12);

        // Reset right after an accept drops the responses and the pointer.
        step(1'b0, 4'b1001, lanes(9, 0, 0, 3), lanes(9, 0, 0, 4), mg, og, ob, orv);
        check("mid_gnt", og, 4'b1001);
        step(1'b1, 4'b1111, fa, fb, mg, og, ob, orv);
        check("mid_rv_rst", orv, 4'b0000);
        check("mid_data", rsp_data, zero);
        step(1'b0, 4'b0000, zero, zero, mg, og, ob, orv);
        check("mid_rv_after", orv, 4'b0000);
        step(1'b0, 4'b1111, fa, fb, mg, og, ob, orv);
        check("mid_ptr", og, 4'b0011);

        // Random traffic honouring the requester contract.
        pend = '0;
        pa   = '0;
        pb   = '0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            r = ($urandom_range(63) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(1) == 1) begin
                        pend[i]       = 1'b1;
                        pa[i*W +: W] = rand_op();
                        pb[i*W +: W] = rand_op();
                    end
                end else if ($urandom_range(15) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            step(r, pend, pa, pb, mg, og, ob, orv);
            pend = pend & ~mg;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/add_pool_arb.md
# add_pool_arb

Round-robin arbiter and scheduler sharing a fixed pool of W-bit adders among NREQ requesters. It sits between independent datapath state machines and the shared adder resources they would otherwise each duplicate. It grants up to NADD requests per cycle, routes operands to the granted adders and returns each sum to its requester as a registered response.

## Interface
- NREQ, 4: number of requesters; must be ≥ 2.
- NADD, 2: number of shared adders; must be ≥ 1.
- W, 32: operand and result width.

- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request; held high until granted.
- opa  in  NREQ*W  operand A; lane i at bits [i*W +: W].
- opb  in  NREQ*W  operand B; same packing as opa.
- gnt  out  NREQ  combinational grant; `req[i] & gnt[i]` means the request is accepted this cycle.
- rsp_valid  out  NREQ  one-cycle pulse per accepted request.
- rsp_data  out  NREQ*W  sum for each lane; valid while the matching rsp_valid bit is high.
- busy  out  1  high in any cycle where all NADD adders are granted.

## Operation
- The block holds a round-robin pointer `ptr`, range 0..NREQ-1.
- Grant scan:
  - Scan lanes ptr, ptr+1, … with wrap-around mod NREQ.
  - Grant the first min(NADD, popcount(req)) lanes that have req high.
  - The k-th granted lane in scan order uses adder k.
- Pointer update:
  - If at least one grant is issued, `ptr <= (last granted lane + 1) mod NREQ`.
  - If there are no grants, ptr is unchanged.
- Arithmetic: sum = (opa_i + opb_i) mod 2^W. Carry-out is discarded and no flag is raised.
- Response registers:
  - For each accepted lane i, rsp_data[i] is loaded with its sum and rsp_valid[i] is set.
  - For lanes not accepted, rsp_valid[i] is cleared and rsp_data[i] holds its previous value.
- Requester contract:
  - Operands must be stable while req is high and not yet granted.
  - A requester may re-request in the cycle after its grant.
- NADD ≥ NREQ: every pending request is granted every cycle.
- Dropping req before grant is legal. The lane loses its turn and the pointer is not affected.
- busy = (number of grants this cycle == NADD).
- While rst is high, gnt is forced to 0 and busy to 0.

## Timing
- Reset values:
  - ptr = 0.
  - rsp_valid = 0.
  - rsp_data = 0.
  - All pipeline stages are cleared.
- Grant is same-cycle: gnt depends combinationally on req and ptr.
- Response latency is 1 cycle: rsp_valid[i] is high exactly in the cycle after the accept cycle.
- Throughput: NADD results per cycle sustained, with no bubbles between consecutive grants.
- Reset mid-operation: any request accepted in the cycle before rst goes high produces no rsp_valid. The response registers are cleared at that edge.
- Back-to-back accepts on the same lane give consecutive rsp_valid pulses, each with its own sum.
- Simultaneous request from every lane with NADD=2, NREQ=4: grants rotate {0,1}, {2,3}, {0,1}, …

## Configuration
- Macro ADD_POOL_ARB_PIPE_EN.
- Defined:
  - An extra register stage sits between the adder outputs and the rsp registers.
  - Response latency is 2 cycles and throughput is unchanged.
  - rst clears both stages, so in-flight results from up to 2 prior cycles are dropped.
- Undefined:
  - Latency is 1 cycle, as described above.
  - The sum is computed and registered in the accept cycle.

## Test plan
- Reset: hold rst 2 cycles, then release.
  - During rst: gnt=0 and busy=0 regardless of req.
  - After release: rsp_valid=0, rsp_data=0, and the first grant with all lanes requesting goes to lanes {0,1}.
- Single request: req[2]=1, opa=5, opb=7.
  - gnt[2]=1 in the same cycle.
  - Next cycle: rsp_valid[2]=1 and rsp_data lane 2 = 12; all other rsp_valid bits are 0.
- Fairness: req=4'b1111 held for 4 cycles, NADD=2.
  - gnt sequence: 0011, 1100, 0011, 1100.
  - busy=1 in every cycle.
  - Each lane gets exactly 2 responses.
- Wrap-around arithmetic: lane 1 with opa=32'hFFFF_FFFF, opb=32'h0000_0002.
  - rsp_data lane 1 = 32'h0000_0001 with no other side effect.
- Reset mid-flight: lanes 0 and 3 accepted at cycle t, rst=1 at cycle t+1.
  - No rsp_valid pulse occurs.
  - rsp_data = 0 after the t+1 edge.
  - ptr = 0: with all lanes requesting after release, lanes {0,1} are granted.
- ADD_POOL_ARB_PIPE_EN defined: lane 0 with opa=10, opb=20.
  - rsp_valid[0]=1 exactly 2 cycles after the accept, with data = 30.
  - Requests accepted on consecutive cycles give consecutive rsp_valid pulses.
